// File: rtl/port_in8_sync.sv
// port_in8_sync: memory-mapped bank of eight 8-bit input ports.
// Each external port passes through a two-flop synchronizer. The CPU reads
// port values at BASE..BASE+7, the change flags at BASE+8 (read-to-clear) and
// the interrupt mask at BASE+9 (also writable). irq is a registered level.
//
// Read response: data_valid is a one-cycle pulse. It is high in the cycle
// after the edge that sampled read==1 with a decoded address, and data_out
// then holds that read's response. data_out keeps its value until the next
// decoded read. There is no ready/back-pressure; every decoded read strobe
// produces exactly one response.
module port_in8_sync #(
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] data_in,
    input  logic [7:0] port_in_00,
    input  logic [7:0] port_in_01,
    input  logic [7:0] port_in_02,
    input  logic [7:0] port_in_03,
    input  logic [7:0] port_in_04,
    input  logic [7:0] port_in_05,
    input  logic [7:0] port_in_06,
    input  logic [7:0] port_in_07,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       irq
);

    logic [7:0] port_raw [8];
    logic [7:0] s1 [8];
    logic [7:0] s2 [8];
    logic [7:0] p  [8];

    logic [7:0] flags;
    logic [7:0] mask;
    logic [7:0] chg;
    logic [7:0] flags_next;
    logic [7:0] mask_next;
    logic [7:0] offset;
    logic       in_window;
    logic       rd_hit;
    logic [7:0] rd_data;

    assign port_raw[0] = port_in_00;
    assign port_raw[1] = port_in_01;
    assign port_raw[2] = port_in_02;
    assign port_raw[3] = port_in_03;
    assign port_raw[4] = port_in_04;
    assign port_raw[5] = port_in_05;
    assign port_raw[6] = port_in_06;
    assign port_raw[7] = port_in_07;

    // Change detect and flag/mask next-state; a set from chg beats an F8 clear.
    always_comb begin
        chg       = 8'h00;
        offset    = address - BASE_ADDR;
        in_window = (address >= BASE_ADDR) && (offset < 8'd10);
        for (int i = 0; i < 8; i++) begin
            chg[i] = (s2[i] != p[i]);
        end
        flags_next = flags | chg;
        if (read && in_window && offset == 8'd8) begin
            flags_next = chg;
        end
        mask_next = mask;
        if (write && in_window && offset == 8'd9) begin
            mask_next = data_in;
        end
    end

    // Read decode: select the response for a decoded read address.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 8'h00;
        if (read && in_window) begin
            rd_hit = 1'b1;
            if (offset < 8'd8) begin
                rd_data = s2[offset[2:0]];
            end else if (offset == 8'd8) begin
                rd_data = flags;
            end else begin
                rd_data = mask;
            end
        end
    end

    // Synchronizers, flag/mask registers, read response and irq.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                s1[i] <= 8'h00;
                s2[i] <= 8'h00;
                p[i]  <= 8'h00;
            end
            flags      <= 8'h00;
            mask       <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                s1[i] <= port_raw[i];
                s2[i] <= s1[i];
                p[i]  <= s2[i];
            end
            flags      <= flags_next;
            mask       <= mask_next;
            irq        <= |(flags_next & mask_next);
            data_valid <= rd_hit;
            if (rd_hit) begin
                data_out <= rd_data;
            end
        end
    end

endmodule
